// File: rtl/correlation_pkg.sv
// Shared sizing and types for the correlation window accumulator.
package correlation_pkg;

  localparam int unsigned PIXEL_SIZE    = 8;
  localparam int unsigned LINE_SIZE     = 10;
  localparam int unsigned NUM_TEMPLATES = 10;
  localparam int unsigned WINDOW_LINES  = 10;
  localparam int unsigned ELEM_WIDTH    = 2 * PIXEL_SIZE;

  // Sum width that can hold LINE_SIZE*WINDOW_LINES full-scale elements without wrap
  function automatic int unsigned acc_width(input int unsigned pixel_size,
                                            input int unsigned line_size,
                                            input int unsigned window_lines);
    return 2 * pixel_size + $clog2(line_size * window_lines);
  endfunction

  localparam int unsigned ACC_WIDTH      = acc_width(PIXEL_SIZE, LINE_SIZE, WINDOW_LINES);
  localparam int unsigned LINE_CNT_WIDTH = $clog2(WINDOW_LINES);
  localparam int unsigned NUM_SUMS       = 2 + NUM_TEMPLATES;

  typedef logic [ELEM_WIDTH-1:0] elem_t;
  typedef logic [ACC_WIDTH-1:0]  acc_t;

endpackage

// File: rtl/line_adder_tree.sv
// Combinational unsigned sum of N elements, each zero-extended to OUT_W.
module line_adder_tree #(
  parameter int unsigned N     = 10,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 23
) (
  input  logic [N-1:0][IN_W-1:0] elems,
  output logic [OUT_W-1:0]       sum_c
);

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum_c = sum_c + OUT_W'(elems[i]);
    end
  end

endmodule

// File: rtl/correlation_window_accumulator.sv
// Reduces each incoming line, accumulates WINDOW_LINES lines into window sums,
// and holds each window result in a single valid/ready output register.
module correlation_window_accumulator
  import correlation_pkg::*;
(
  input  logic                                                CLK,
  input  logic                                                RST_N,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic                                                window_restart,
  input  logic [LINE_SIZE-1:0][ELEM_WIDTH-1:0]                I_in_line,
  input  logic [LINE_SIZE-1:0][ELEM_WIDTH-1:0]                I_square_in_line,
  input  logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][ELEM_WIDTH-1:0] T_x_I_in_lines,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [ACC_WIDTH-1:0]                                I_sum,
  output logic [ACC_WIDTH-1:0]                                I_square_sum,
  output logic [NUM_TEMPLATES-1:0][ACC_WIDTH-1:0]             T_x_I_sum
);

  if (WINDOW_LINES < 2) begin : g_window_check
    $error("WINDOW_LINES must be at least 2");
  end

  // Index 0: I, index 1: I^2, index 2+t: T*I for template t
  logic [NUM_SUMS-1:0][ACC_WIDTH-1:0] line_sum_c;
  logic [NUM_SUMS-1:0][ACC_WIDTH-1:0] line_sum_q;
  logic [NUM_SUMS-1:0][ACC_WIDTH-1:0] acc_q;
  logic [NUM_SUMS-1:0][ACC_WIDTH-1:0] acc_next_c;
  logic                               rvalid;
  logic [LINE_CNT_WIDTH-1:0]          line_cnt;
  logic                               accept_c;
  logic                               last_line_c;

  line_adder_tree #(.N(LINE_SIZE), .IN_W(ELEM_WIDTH), .OUT_W(ACC_WIDTH)) u_i_tree (
    .elems (I_in_line),
    .sum_c (line_sum_c[0])
  );

  line_adder_tree #(.N(LINE_SIZE), .IN_W(ELEM_WIDTH), .OUT_W(ACC_WIDTH)) u_i_square_tree (
    .elems (I_square_in_line),
    .sum_c (line_sum_c[1])
  );

  for (genvar t = 0; t < int'(NUM_TEMPLATES); t++) begin : g_tmpl
    line_adder_tree #(.N(LINE_SIZE), .IN_W(ELEM_WIDTH), .OUT_W(ACC_WIDTH)) u_txi_tree (
      .elems (T_x_I_in_lines[t]),
      .sum_c (line_sum_c[2+t])
    );
  end

  // A held result blocks intake, so it can never be overwritten
  assign in_ready    = !(out_valid && !out_ready);
  assign accept_c    = in_valid && in_ready;
  assign last_line_c = rvalid && (line_cnt == LINE_CNT_WIDTH'(WINDOW_LINES - 1));

  always_comb begin
    acc_next_c = '0;
    for (int k = 0; k < int'(NUM_SUMS); k++) begin
      acc_next_c[k] = acc_q[k] + line_sum_q[k];
    end
  end

  // Stage R: registered line sums
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rvalid     <= 1'b0;
      line_sum_q <= '0;
    end else begin
      rvalid <= accept_c;
      if (accept_c) begin
        line_sum_q <= line_sum_c;
      end
    end
  end

  // Stage A: window accumulation; restart discards the line sitting in stage R
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q    <= '0;
      line_cnt <= '0;
    end else if (window_restart) begin
      acc_q    <= '0;
      line_cnt <= '0;
    end else if (rvalid) begin
      if (last_line_c) begin
        acc_q    <= '0;
        line_cnt <= '0;
      end else begin
        acc_q    <= acc_next_c;
        line_cnt <= line_cnt + LINE_CNT_WIDTH'(1);
      end
    end
  end

  // Output register: load wins over the handshake clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid    <= 1'b0;
      I_sum        <= '0;
      I_square_sum <= '0;
      T_x_I_sum    <= '0;
    end else if (last_line_c && !window_restart) begin
      out_valid    <= 1'b1;
      I_sum        <= acc_next_c[0];
      I_square_sum <= acc_next_c[1];
      for (int t = 0; t < int'(NUM_TEMPLATES); t++) begin
        T_x_I_sum[t] <= acc_next_c[2+t];
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
